// File: rtl/seg_scan_capture.sv
// seg_scan_capture
// Receive side of a four-digit multiplexed seven-segment display.
// It samples the scanned digit-select and segment lines and decodes each
// active-low segment pattern back to a 4-bit digit code. Complete frames
// (ones, tens, hundreds, thousands) are rebuilt and shown on the outputs.
//
// Build option:
//    SEG_CAPTURE_SYNC_EN - when defined, a two-flop synchronizer sits
//                          between the pins and the pair register. Use it
//                          when digit/number come from asynchronous
//                          external pins. Acceptance latency becomes
//                          STABLE_CYCLES + 2 clocks.

module seg_scan_capture #(
   parameter int STABLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] digit,
   input  logic [6:0] number,
   output logic [3:0] ones,
   output logic [3:0] tens,
   output logic [3:0] hundreds,
   output logic [3:0] thousands,
   output logic       frame_valid,
   output logic       seq_error,
   output logic       seg_error
);

   localparam logic [3:0]  STABLE_COUNT = 4'(STABLE_CYCLES);
   localparam logic [10:0] IDLE_PAIR    = 11'h7FF;
   localparam logic [3:0]  BLANK_CODE   = 4'd10;
   localparam logic [3:0]  BAD_CODE     = 4'd15;

   typedef enum logic [0:0] {
      SYNC    = 1'b0,
      CAPTURE = 1'b1
   } state_t;

   logic [10:0] w_pairIn;

   logic [10:0] r_pair;
   logic [3:0]  r_holdCount;
   logic        r_taken;
   logic        w_accept;

   logic [3:0]  w_digitCode;
   logic        w_segIllegal;
   logic        w_selIdle;
   logic        w_selValid;
   logic [1:0]  w_selPos;

   state_t      r_state;
   state_t      w_stateNext;
   logic [1:0]  r_pos;
   logic [1:0]  w_posNext;

   logic [3:0]  r_shOnes;
   logic [3:0]  r_shTens;
   logic [3:0]  r_shHundreds;
   logic [3:0]  w_shOnesNext;
   logic [3:0]  w_shTensNext;
   logic [3:0]  w_shHundredsNext;

   logic [3:0]  r_ones;
   logic [3:0]  r_tens;
   logic [3:0]  r_hundreds;
   logic [3:0]  r_thousands;
   logic [3:0]  w_onesNext;
   logic [3:0]  w_tensNext;
   logic [3:0]  w_hundredsNext;
   logic [3:0]  w_thousandsNext;

   logic        r_frameValid;
   logic        r_seqError;
   logic        r_segError;
   logic        w_frameValidNext;
   logic        w_seqErrorNext;
   logic        w_segErrorNext;

`ifdef SEG_CAPTURE_SYNC_EN
   logic [10:0] r_syncMeta;
   logic [10:0] r_syncStable;

   // Two-flop synchronizer; resets to the idle pattern so nothing looks active
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_syncMeta   <= IDLE_PAIR;
         r_syncStable <= IDLE_PAIR;
      end else begin
         r_syncMeta   <= {digit, number};
         r_syncStable <= r_syncMeta;
      end
   end

   assign w_pairIn = r_syncStable;
`else
   assign w_pairIn = {digit, number};
`endif

   // Pair register and saturating hold counter. The taken flag stops a
   // long-held pair from being accepted again once the counter saturates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pair      <= IDLE_PAIR;
         r_holdCount <= 4'd0;
         r_taken     <= 1'b0;
      end else begin
         r_pair <= w_pairIn;
         if (w_pairIn != r_pair) begin
            r_holdCount <= 4'd1;
            r_taken     <= 1'b0;
         end else begin
            if (r_holdCount != 4'hF) begin
               r_holdCount <= r_holdCount + 4'd1;
            end
            if (w_accept) begin
               r_taken <= 1'b1;
            end
         end
      end
   end

   assign w_accept = (r_holdCount == STABLE_COUNT) && !r_taken;

   // Segment decoder: active-low gfedcba back to a digit code, 15 if unknown
   always_comb begin
      w_digitCode = BAD_CODE;
      case (r_pair[6:0])
         7'b1000000: w_digitCode = 4'd0;
         7'b1111001: w_digitCode = 4'd1;
         7'b0100100: w_digitCode = 4'd2;
         7'b0110000: w_digitCode = 4'd3;
         7'b0011001: w_digitCode = 4'd4;
         7'b0010010: w_digitCode = 4'd5;
         7'b0000010: w_digitCode = 4'd6;
         7'b1111000: w_digitCode = 4'd7;
         7'b0000000: w_digitCode = 4'd8;
         7'b0011000: w_digitCode = 4'd9;
         7'b1111111: w_digitCode = BLANK_CODE;
         default:    w_digitCode = BAD_CODE;
      endcase
      w_segIllegal = (w_digitCode == BAD_CODE);
   end

   // Digit-select classifier: idle, one of four positions, or malformed
   always_comb begin
      w_selIdle  = (r_pair[10:7] == 4'b1111);
      w_selValid = 1'b1;
      w_selPos   = 2'd0;
      case (r_pair[10:7])
         4'b1110: w_selPos = 2'd0;
         4'b1101: w_selPos = 2'd1;
         4'b1011: w_selPos = 2'd2;
         4'b0111: w_selPos = 2'd3;
         default: w_selValid = 1'b0;
      endcase
   end

   // Frame-assembly state, shadow digits, outputs and error pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= SYNC;
         r_pos        <= 2'd0;
         r_shOnes     <= BLANK_CODE;
         r_shTens     <= BLANK_CODE;
         r_shHundreds <= BLANK_CODE;
         r_ones       <= BLANK_CODE;
         r_tens       <= BLANK_CODE;
         r_hundreds   <= BLANK_CODE;
         r_thousands  <= BLANK_CODE;
         r_frameValid <= 1'b0;
         r_seqError   <= 1'b0;
         r_segError   <= 1'b0;
      end else begin
         r_state      <= w_stateNext;
         r_pos        <= w_posNext;
         r_shOnes     <= w_shOnesNext;
         r_shTens     <= w_shTensNext;
         r_shHundreds <= w_shHundredsNext;
         r_ones       <= w_onesNext;
         r_tens       <= w_tensNext;
         r_hundreds   <= w_hundredsNext;
         r_thousands  <= w_thousandsNext;
         r_frameValid <= w_frameValidNext;
         r_seqError   <= w_seqErrorNext;
         r_segError   <= w_segErrorNext;
      end
   end

   // Next-state logic. Only an accepted, non-idle pair changes anything.
   // Out-of-order ones pairs restart a frame; any other out-of-order pair
   // drops back to SYNC.
   always_comb begin
      w_stateNext      = r_state;
      w_posNext        = r_pos;
      w_shOnesNext     = r_shOnes;
      w_shTensNext     = r_shTens;
      w_shHundredsNext = r_shHundreds;
      w_onesNext       = r_ones;
      w_tensNext       = r_tens;
      w_hundredsNext   = r_hundreds;
      w_thousandsNext  = r_thousands;
      w_frameValidNext = 1'b0;
      w_seqErrorNext   = 1'b0;
      w_segErrorNext   = 1'b0;

      if (w_accept && !w_selIdle) begin
         w_segErrorNext = w_segIllegal;
         if (!w_selValid) begin
            w_seqErrorNext = 1'b1;
            w_stateNext    = SYNC;
            w_posNext      = 2'd0;
         end else begin
            case (r_state)
               SYNC: begin
                  if (w_selPos == 2'd0) begin
                     w_shOnesNext = w_digitCode;
                     w_posNext    = 2'd1;
                     w_stateNext  = CAPTURE;
                  end
               end
               CAPTURE: begin
                  if (w_selPos == r_pos) begin
                     case (r_pos)
                        2'd0: begin
                           w_shOnesNext = w_digitCode;
                           w_posNext    = 2'd1;
                        end
                        2'd1: begin
                           w_shTensNext = w_digitCode;
                           w_posNext    = 2'd2;
                        end
                        2'd2: begin
                           w_shHundredsNext = w_digitCode;
                           w_posNext        = 2'd3;
                        end
                        default: begin
                           w_onesNext       = r_shOnes;
                           w_tensNext       = r_shTens;
                           w_hundredsNext   = r_shHundreds;
                           w_thousandsNext  = w_digitCode;
                           w_frameValidNext = 1'b1;
                           w_posNext        = 2'd0;
                        end
                     endcase
                  end else begin
                     w_seqErrorNext = 1'b1;
                     if (w_selPos == 2'd0) begin
                        w_shOnesNext = w_digitCode;
                        w_posNext    = 2'd1;
                     end else begin
                        w_stateNext = SYNC;
                        w_posNext   = 2'd0;
                     end
                  end
               end
               default: begin
                  w_stateNext = SYNC;
                  w_posNext   = 2'd0;
               end
            endcase
         end
      end
   end

   assign ones        = r_ones;
   assign tens        = r_tens;
   assign hundreds    = r_hundreds;
   assign thousands   = r_thousands;
   assign frame_valid = r_frameValid;
   assign seq_error   = r_seqError;
   assign seg_error   = r_segError;

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture
// Bench for seg_scan_capture.
// dut1 runs with STABLE_CYCLES=1 and is driven from a vector table through
// a scoreboard. dut3 runs with STABLE_CYCLES=3 and covers the hold-time
// cases. The reset and latency checks are hand-written sequences.

module tb_seg_scan_capture;

`ifdef SEG_CAPTURE_SYNC_EN
   localparam int SYNC_EXTRA = 2;
`else
   localparam int SYNC_EXTRA = 0;
`endif
   localparam int LAT1 = 1 + SYNC_EXTRA;
   localparam int LAT3 = 3 + SYNC_EXTRA;

   localparam logic [3:0] SEL_ONES  = 4'b1110;
   localparam logic [3:0] SEL_TENS  = 4'b1101;
   localparam logic [3:0] SEL_HUND  = 4'b1011;
   localparam logic [3:0] SEL_THOU  = 4'b0111;
   localparam logic [3:0] SEL_IDLE  = 4'b1111;
   localparam logic [3:0] SEL_BAD   = 4'b1100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_JUNK  = 7'b1010101;

   typedef struct {
      int         idx;
      logic [3:0] dsel;
      logic [6:0] seg;
      logic       fv;
      logic       seqE;
      logic       segE;
      logic [3:0] o;
      logic [3:0] t;
      logic [3:0] h;
      logic [3:0] th;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   longint     cyc = 0;

   logic [3:0] d1Digit  = SEL_IDLE;
   logic [6:0] d1Number = SEG_BLANK;
   logic [3:0] d1Ones, d1Tens, d1Hund, d1Thou;
   logic       d1Fv, d1SeqE, d1SegE;

   logic [3:0] d3Digit  = SEL_IDLE;
   logic [6:0] d3Number = SEG_BLANK;
   logic [3:0] d3Ones, d3Tens, d3Hund, d3Thou;
   logic       d3Fv, d3SeqE, d3SegE;

   int checkCount = 0;
   int errorCount = 0;

   vec_t vecs[$];
   vec_t sbQueue[$];

   seg_scan_capture #(.STABLE_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .digit(d1Digit), .number(d1Number),
      .ones(d1Ones), .tens(d1Tens), .hundreds(d1Hund), .thousands(d1Thou),
      .frame_valid(d1Fv), .seq_error(d1SeqE), .seg_error(d1SegE)
   );

   seg_scan_capture #(.STABLE_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .digit(d3Digit), .number(d3Number),
      .ones(d3Ones), .tens(d3Tens), .hundreds(d3Hund), .thousands(d3Thou),
      .frame_valid(d3Fv), .seq_error(d3SeqE), .seg_error(d3SegE)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Rising-edge counter used for latency measurements
   always @(posedge clk) cyc <= cyc + 1;

   // Reference segment encoding, active-low gfedcba
   function automatic logic [6:0] segOf(input int n);
      case (n)
         0:       return 7'b1000000;
         1:       return 7'b1111001;
         2:       return 7'b0100100;
         3:       return 7'b0110000;
         4:       return 7'b0011001;
         5:       return 7'b0010010;
         6:       return 7'b0000010;
         7:       return 7'b1111000;
         8:       return 7'b0000000;
         9:       return 7'b0011000;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual != expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic addVec(input logic [3:0] d, input logic [6:0] s,
                         input logic fv, input logic se, input logic ge,
                         input int o, input int t, input int h, input int th);
      vec_t v;
      v.idx = vecs.size(); v.dsel = d; v.seg = s;
      v.fv = fv; v.seqE = se; v.segE = ge;
      v.o = 4'(o); v.t = 4'(t); v.h = 4'(h); v.th = 4'(th);
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      d1Digit  = v.dsel;
      d1Number = v.seg;
      sbQueue.push_back(v);
   endtask

   task automatic compareFront();
      vec_t e;
      e = sbQueue.pop_front();
      checkOutput($sformatf("v%0d_frame_valid", e.idx), int'(d1Fv),   int'(e.fv));
      checkOutput($sformatf("v%0d_seq_error", e.idx),   int'(d1SeqE), int'(e.seqE));
      checkOutput($sformatf("v%0d_seg_error", e.idx),   int'(d1SegE), int'(e.segE));
      checkOutput($sformatf("v%0d_ones", e.idx),        int'(d1Ones), int'(e.o));
      checkOutput($sformatf("v%0d_tens", e.idx),        int'(d1Tens), int'(e.t));
      checkOutput($sformatf("v%0d_hundreds", e.idx),    int'(d1Hund), int'(e.h));
      checkOutput($sformatf("v%0d_thousands", e.idx),   int'(d1Thou), int'(e.th));
   endtask

   task automatic drive1(input logic [3:0] d, input logic [6:0] s);
      d1Digit  = d;
      d1Number = s;
   endtask

   task automatic drive3(input logic [3:0] d, input logic [6:0] s);
      d3Digit  = d;
      d3Number = s;
   endtask

   initial begin
      int fvSeen;
      int found;
      longint kThou;
      longint seenCyc;

      // Expected outputs after each pair is accepted
      // First frame 1,2,3,4 shown as ones=4 .. thousands=1, then back-to-back frames
      addVec(SEL_ONES, segOf(4), 0, 0, 0, 10, 10, 10, 10);
      addVec(SEL_TENS, segOf(3), 0, 0, 0, 10, 10, 10, 10);
      addVec(SEL_HUND, segOf(2), 0, 0, 0, 10, 10, 10, 10);
      addVec(SEL_THOU, segOf(1), 1, 0, 0, 4, 3, 2, 1);
      addVec(SEL_ONES, segOf(5), 0, 0, 0, 4, 3, 2, 1);
      addVec(SEL_TENS, segOf(6), 0, 0, 0, 4, 3, 2, 1);
      addVec(SEL_HUND, segOf(7), 0, 0, 0, 4, 3, 2, 1);
      addVec(SEL_THOU, segOf(8), 1, 0, 0, 5, 6, 7, 8);
      addVec(SEL_ONES, segOf(9), 0, 0, 0, 5, 6, 7, 8);
      addVec(SEL_TENS, segOf(0), 0, 0, 0, 5, 6, 7, 8);
      addVec(SEL_HUND, segOf(1), 0, 0, 0, 5, 6, 7, 8);
      addVec(SEL_THOU, segOf(2), 1, 0, 0, 9, 0, 1, 2);
      // Scan order ones, tens, thousands: error, then resync on a clean frame
      addVec(SEL_ONES, segOf(3), 0, 0, 0, 9, 0, 1, 2);
      addVec(SEL_TENS, segOf(4), 0, 0, 0, 9, 0, 1, 2);
      addVec(SEL_THOU, segOf(5), 0, 1, 0, 9, 0, 1, 2);
      addVec(SEL_HUND, segOf(6), 0, 0, 0, 9, 0, 1, 2);
      addVec(SEL_THOU, segOf(7), 0, 0, 0, 9, 0, 1, 2);
      addVec(SEL_ONES, segOf(1), 0, 0, 0, 9, 0, 1, 2);
      addVec(SEL_TENS, segOf(2), 0, 0, 0, 9, 0, 1, 2);
      addVec(SEL_HUND, segOf(3), 0, 0, 0, 9, 0, 1, 2);
      addVec(SEL_THOU, segOf(4), 1, 0, 0, 1, 2, 3, 4);
      // Illegal segments on tens decode to 15
      addVec(SEL_ONES, segOf(0), 0, 0, 0, 1, 2, 3, 4);
      addVec(SEL_TENS, SEG_JUNK, 0, 0, 1, 1, 2, 3, 4);
      addVec(SEL_HUND, segOf(5), 0, 0, 0, 1, 2, 3, 4);
      addVec(SEL_THOU, segOf(6), 1, 0, 0, 0, 15, 5, 6);
      // Blank on tens decodes to 10 without error
      addVec(SEL_ONES, segOf(7), 0, 0, 0, 0, 15, 5, 6);
      addVec(SEL_TENS, SEG_BLANK, 0, 0, 0, 0, 15, 5, 6);
      addVec(SEL_HUND, segOf(8), 0, 0, 0, 0, 15, 5, 6);
      addVec(SEL_THOU, segOf(9), 1, 0, 0, 7, 10, 8, 9);
      // Early ones restarts the frame
      addVec(SEL_ONES, segOf(1), 0, 0, 0, 7, 10, 8, 9);
      addVec(SEL_TENS, segOf(2), 0, 0, 0, 7, 10, 8, 9);
      addVec(SEL_ONES, segOf(3), 0, 1, 0, 7, 10, 8, 9);
      addVec(SEL_TENS, segOf(4), 0, 0, 0, 7, 10, 8, 9);
      addVec(SEL_HUND, segOf(5), 0, 0, 0, 7, 10, 8, 9);
      addVec(SEL_THOU, segOf(6), 1, 0, 0, 3, 4, 5, 6);
      // Malformed digit select
      addVec(SEL_ONES, segOf(1), 0, 0, 0, 3, 4, 5, 6);
      addVec(SEL_BAD,  segOf(2), 0, 1, 0, 3, 4, 5, 6);
      addVec(SEL_TENS, segOf(3), 0, 0, 0, 3, 4, 5, 6);
      addVec(SEL_ONES, segOf(4), 0, 0, 0, 3, 4, 5, 6);
      addVec(SEL_TENS, segOf(5), 0, 0, 0, 3, 4, 5, 6);
      addVec(SEL_HUND, segOf(6), 0, 0, 0, 3, 4, 5, 6);
      addVec(SEL_THOU, segOf(7), 1, 0, 0, 4, 5, 6, 7);
      // Idle pairs inside a frame are ignored, even with junk segments
      addVec(SEL_ONES, segOf(8), 0, 0, 0, 4, 5, 6, 7);
      addVec(SEL_IDLE, SEG_BLANK, 0, 0, 0, 4, 5, 6, 7);
      addVec(SEL_TENS, segOf(9), 0, 0, 0, 4, 5, 6, 7);
      addVec(SEL_IDLE, SEG_JUNK, 0, 0, 0, 4, 5, 6, 7);
      addVec(SEL_HUND, segOf(0), 0, 0, 0, 4, 5, 6, 7);
      addVec(SEL_THOU, segOf(1), 1, 0, 0, 8, 9, 0, 1);
      // Order error and segment error on the same acceptance
      addVec(SEL_ONES, segOf(2), 0, 0, 0, 8, 9, 0, 1);
      addVec(SEL_THOU, SEG_JUNK, 0, 1, 1, 8, 9, 0, 1);
      addVec(SEL_IDLE, SEG_BLANK, 0, 0, 0, 8, 9, 0, 1);
      addVec(SEL_IDLE, SEG_BLANK, 0, 0, 0, 8, 9, 0, 1);
      addVec(SEL_IDLE, SEG_BLANK, 0, 0, 0, 8, 9, 0, 1);

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("reset_ones",        int'(d1Ones), 10);
      checkOutput("reset_tens",        int'(d1Tens), 10);
      checkOutput("reset_hundreds",    int'(d1Hund), 10);
      checkOutput("reset_thousands",   int'(d1Thou), 10);
      checkOutput("reset_frame_valid", int'(d1Fv),   0);
      checkOutput("reset_seq_error",   int'(d1SeqE), 0);
      checkOutput("reset_seg_error",   int'(d1SegE), 0);
      checkOutput("reset_dut3_ones",   int'(d3Ones), 10);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Table-driven run through the scoreboard
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         while (sbQueue.size() > LAT1) compareFront();
         applyStimulus(vecs[i]);
      end
      while (sbQueue.size() > 0) begin
         @(negedge clk);
         compareFront();
      end

      // Asynchronous reset in the middle of a frame
      @(negedge clk); drive1(SEL_ONES, segOf(1));
      @(negedge clk); drive1(SEL_TENS, segOf(2));
      @(negedge clk); drive1(SEL_IDLE, SEG_BLANK);
      repeat (LAT1 + 1) @(negedge clk);
      checkOutput("partial_held_ones",      int'(d1Ones), 8);
      checkOutput("partial_held_thousands", int'(d1Thou), 1);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_reset_ones",      int'(d1Ones), 10);
      checkOutput("async_reset_tens",      int'(d1Tens), 10);
      checkOutput("async_reset_hundreds",  int'(d1Hund), 10);
      checkOutput("async_reset_thousands", int'(d1Thou), 10);
      @(negedge clk); rst = 1'b0;
      fvSeen = 0;
      @(negedge clk); drive1(SEL_HUND, segOf(3));
      @(negedge clk); if (d1Fv) fvSeen++; drive1(SEL_THOU, segOf(4));
      @(negedge clk); if (d1Fv) fvSeen++; drive1(SEL_IDLE, SEG_BLANK);
      for (int i = 0; i < LAT1 + 4; i++) begin
         @(negedge clk);
         if (d1Fv) fvSeen++;
      end
      checkOutput("post_reset_no_frame",   fvSeen, 0);
      checkOutput("post_reset_ones",       int'(d1Ones), 10);
      checkOutput("post_reset_thousands",  int'(d1Thou), 10);
      // A fresh ones digit brings frames back
      @(negedge clk); drive1(SEL_ONES, segOf(5));
      @(negedge clk); drive1(SEL_TENS, segOf(6));
      @(negedge clk); drive1(SEL_HUND, segOf(7));
      @(negedge clk); drive1(SEL_THOU, segOf(8));
      kThou = cyc + 1;
      @(negedge clk); drive1(SEL_IDLE, SEG_BLANK);
      found = 0;
      seenCyc = 0;
      for (int i = 0; i < 20; i++) begin
         if (d1Fv) begin found = 1; seenCyc = cyc; break; end
         @(negedge clk);
      end
      checkOutput("resync_frame_seen",  found, 1);
      checkOutput("resync_latency",     int'(seenCyc - kThou), LAT1);
      checkOutput("resync_ones",        int'(d1Ones), 5);
      checkOutput("resync_tens",        int'(d1Tens), 6);
      checkOutput("resync_hundreds",    int'(d1Hund), 7);
      checkOutput("resync_thousands",   int'(d1Thou), 8);

      // STABLE_CYCLES=3, each position held only 2 clocks: nothing accepted
      fvSeen = 0;
      for (int p = 0; p < 4; p++) begin
         for (int hc = 0; hc < 2; hc++) begin
            @(negedge clk);
            if (d3Fv || d3SeqE) fvSeen++;
            case (p)
               0: drive3(SEL_ONES, segOf(1));
               1: drive3(SEL_TENS, segOf(2));
               2: drive3(SEL_HUND, segOf(3));
               default: drive3(SEL_THOU, segOf(4));
            endcase
         end
      end
      @(negedge clk); drive3(SEL_IDLE, SEG_BLANK);
      for (int i = 0; i < LAT3 + 4; i++) begin
         @(negedge clk);
         if (d3Fv || d3SeqE) fvSeen++;
      end
      checkOutput("hold2_no_frame", fvSeen, 0);
      checkOutput("hold2_ones",     int'(d3Ones), 10);

      // Held 3 clocks: frame completes LAT3 edges after thousands enters
      for (int p = 0; p < 4; p++) begin
         for (int hc = 0; hc < 3; hc++) begin
            @(negedge clk);
            case (p)
               0: drive3(SEL_ONES, segOf(1));
               1: drive3(SEL_TENS, segOf(2));
               2: drive3(SEL_HUND, segOf(3));
               default: drive3(SEL_THOU, segOf(4));
            endcase
            if (p == 3 && hc == 0) kThou = cyc + 1;
         end
      end
      @(negedge clk); drive3(SEL_IDLE, SEG_BLANK);
      found = 0;
      seenCyc = 0;
      for (int i = 0; i < 20; i++) begin
         if (d3Fv) begin found = 1; seenCyc = cyc; break; end
         @(negedge clk);
      end
      checkOutput("hold3_frame_seen", found, 1);
      checkOutput("hold3_latency",    int'(seenCyc - kThou), LAT3);
      checkOutput("hold3_ones",       int'(d3Ones), 1);
      checkOutput("hold3_tens",       int'(d3Tens), 2);
      checkOutput("hold3_hundreds",   int'(d3Hund), 3);
      checkOutput("hold3_thousands",  int'(d3Thou), 4);
      @(negedge clk);
      checkOutput("hold3_single_pulse", int'(d3Fv), 0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
